key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 115 +++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer feeding a stability-qualifying FSM.
// Outputs a registered debounced level, edge pulses and a rising-edge counter.
//
// state | meaning
// IDLE  | synchronized input equals q, nothing pending
// CHECK | synchronized input differs from q, counting stable cycles
module key_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             d_raw,
   output logic             q,
   output logic             rise,
   output logic             fall,
   output logic             busy,
   output logic [CNT_W-1:0] press_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      CHECK = 1'b1
   } state_t;

   localparam logic [7:0] CNT_TC = 8'(STABLE_CYCLES - 1);

   logic       s1;
   logic       s2;
   state_t     state;
   state_t     state_nxt;
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;
   logic       q_nxt;
   logic       q_d;
   logic       rise_nxt;
   logic       fall_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= d_raw;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         q     <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         q     <= q_nxt;
         busy  <= (state_nxt == CHECK);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      q_nxt     = q;
      case (state)
         IDLE: begin
            if (s2 != q) begin
               state_nxt = CHECK;
               cnt_nxt   = 8'd1;
            end else begin
               cnt_nxt   = '0;
            end
         end
         CHECK: begin
            if (s2 == q) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_TC) begin
               q_nxt     = s2;
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Pulses come from the registered q against its one-cycle-old copy.
   assign rise_nxt = q & ~q_d;
   assign fall_nxt = ~q & q_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_d       <= 1'b0;
         rise      <= 1'b0;
         fall      <= 1'b0;
         press_cnt <= '0;
      end else begin
         q_d  <= q;
         rise <= rise_nxt;
         fall <= fall_nxt;
         if (rise_nxt) begin
            press_cnt <= press_cnt + CNT_W'(1);
         end
      end
   end

endmodule
